// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Shares one FIFO write port between two producers. Each producer holds a
// level request (with its data word) until it sees a one-cycle acknowledge.
// A two-state FSM (IDLE -> WRITE -> IDLE) picks a winner while the FIFO is
// not full, registers the winner's word onto the FIFO write port and pulses
// fifo_wr together with the winner's ack for exactly one cycle. Because every
// write is followed by an IDLE cycle, the FIFO's full flag has already been
// updated by the time the next grant decision is made, so the FIFO is never
// overwritten.
//
// Arbitration:
//   default                    round-robin; on a tie the winner is the
//                              requester that did not win last (first tie
//                              after reset goes to requester 0).
//   FIFO_ARB_FIXED_PRIO_EN     fixed priority; requester 0 wins every tie.
//
// Parameters:
//   B            data word width (must match the FIFO word width)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   req0/req1    level write requests, held until the matching ack
//   data0/data1  request words, stable while the request is high
//   ack0/ack1    one-cycle pulse: that requester's word is being written
//   fifo_full    FIFO full flag
//   fifo_wr      FIFO write strobe
//   fifo_w_data  FIFO write data
//   grant_id     source of the current or most recent write
//   busy         high during the WRITE cycle
//
// All outputs come straight from flops; none depends combinationally on an
// input.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int B = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic [B-1:0] data0,
    output logic         ack0,
    input  logic         req1,
    input  logic [B-1:0] data1,
    output logic         ack1,
    input  logic         fifo_full,
    output logic         fifo_wr,
    output logic [B-1:0] fifo_w_data,
    output logic         grant_id,
    output logic         busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;

    logic           winner;      // 0 = requester 0, 1 = requester 1
    logic           start;       // grant this cycle (IDLE -> WRITE)

    logic           fifo_wr_next;
    logic           ack0_next;
    logic           ack1_next;
    logic           busy_next;
    logic           grant_id_next;
    logic [B-1:0]   fifo_w_data_next;

    // -----------------------------------------------------------------------
    // Winner selection. With a single request that requester wins, so the
    // lone-request case reduces to "requester 1 wins unless req0 is high".
    // -----------------------------------------------------------------------
`ifdef FIFO_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = ~req0;
    end
`else
    logic last_grant;

    always_comb begin
        if (req0 && req1) begin
            winner = ~last_grant;
        end else begin
            winner = ~req0;
        end
    end

    // Reset value 1 makes the first tie after reset go to requester 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (start) begin
            last_grant <= winner;
        end
    end
`endif

    assign start = (state == IDLE) && !fifo_full && (req0 || req1);

    // -----------------------------------------------------------------------
    // Next-state and next-output logic.
    // -----------------------------------------------------------------------
    // NOTE: every signal gets a default before the case statement so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next       = state;
        fifo_wr_next     = 1'b0;
        ack0_next        = 1'b0;
        ack1_next        = 1'b0;
        busy_next        = 1'b0;
        grant_id_next    = grant_id;      // holds the most recent source
        fifo_w_data_next = fifo_w_data;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next       = WRITE;
                    fifo_wr_next     = 1'b1;
                    busy_next        = 1'b1;
                    ack0_next        = ~winner;
                    ack1_next        = winner;
                    grant_id_next    = winner;
                    fifo_w_data_next = winner ? data1 : data0;
                end
            end
            WRITE: begin
                // Single-cycle write; the following IDLE cycle lets the
                // FIFO's full flag catch up before the next grant.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and output registers.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            fifo_wr     <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            busy        <= 1'b0;
            grant_id    <= 1'b0;
            fifo_w_data <= '0;
        end else begin
            state       <= state_next;
            fifo_wr     <= fifo_wr_next;
            ack0        <= ack0_next;
            ack1        <= ack1_next;
            busy        <= busy_next;
            grant_id    <= grant_id_next;
            fifo_w_data <= fifo_w_data_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Bench for fifo_wr_arbiter. It contains a 4-deep behavioural FIFO fed by the
// DUT's write port, two queue-driven requesters that obey the ack contract,
// and a transaction-level model of the arbiter ("a write happens the cycle
// after an idle cycle that saw a request and a non-full FIFO"). The DUT
// outputs are compared with the model on every falling edge; each scenario
// also checks its write log against hand-computed words and cycle numbers.
// Define FIFO_ARB_FIXED_PRIO_EN for both DUT and bench to test that build.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int B     = 8;
    localparam int DEPTH = 4;

    logic         clk;
    logic         reset;
    logic         req0;
    logic [B-1:0] data0;
    logic         ack0;
    logic         req1;
    logic [B-1:0] data1;
    logic         ack1;
    logic         fifo_full;
    logic         fifo_wr;
    logic [B-1:0] fifo_w_data;
    logic         grant_id;
    logic         busy;

    fifo_wr_arbiter #(.B(B)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .data0       (data0),
        .ack0        (ack0),
        .req1        (req1),
        .data1       (data1),
        .ack1        (ack1),
        .fifo_full   (fifo_full),
        .fifo_wr     (fifo_wr),
        .fifo_w_data (fifo_w_data),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic         gid;
        logic [B-1:0] data;
    } wr_t;

    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc      = 0;

    logic [B-1:0] q0[$];        // words requester 0 still has to send
    logic [B-1:0] q1[$];
    logic [B-1:0] fq[$];        // FIFO contents
    wr_t          wlog[$];      // writes observed on the DUT port
    logic         rd;

    // Samples of DUT outputs taken at the falling edge.
    logic         ack0_s, ack1_s, wr_s;
    logic [B-1:0] wd_s;

    // Arbiter model: what the write port must show in the current cycle.
    logic         m_write;
    logic         m_gid;
    logic [B-1:0] m_data;
    logic         m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic present();
        req0  = (q0.size() != 0);
        data0 = req0 ? q0[0] : '0;
        req1  = (q1.size() != 0);
        data1 = req1 ? q1[0] : '0;
    endtask

    task automatic model_reset();
        m_write = 1'b0;
        m_gid   = 1'b0;
        m_data  = '0;
        m_last  = 1'b1;
    endtask

    // Clears DUT, model, requesters and FIFO; leaves the bench just after a
    // rising edge with reset released.
    task automatic do_reset();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        fq.delete();
        wlog.delete();
        rd        = 1'b0;
        fifo_full = 1'b0;
        ack0_s    = 1'b0;
        ack1_s    = 1'b0;
        wr_s      = 1'b0;
        wd_s      = '0;
        present();
        model_reset();
        #1;
        check("rst_fifo_wr", fifo_wr, 0);
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_w_data", fifo_w_data, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One clock cycle: compare at the falling edge, then advance FIFO, model
    // and requesters at the rising edge.
    task automatic cycle();
        logic w;
        @(negedge clk);
        check("fifo_wr", fifo_wr, m_write);
        check("busy", busy, m_write);
        check("ack0", ack0, m_write && !m_gid);
        check("ack1", ack1, m_write && m_gid);
        check("ack_excl", ack0 & ack1, 0);
        check("grant_id", grant_id, m_gid);
        check("w_data", fifo_w_data, m_data);
        ack0_s = ack0;
        ack1_s = ack1;
        wr_s   = fifo_wr;
        wd_s   = fifo_w_data;
        if (wr_s) wlog.push_back('{cyc, grant_id, wd_s});

        @(posedge clk);
        cyc++;
        if (wr_s) begin
            check("no_overwrite", fifo_full, 0);
            if (!fifo_full) fq.push_back(wd_s);
        end
        if (rd && fq.size() > 0) fq.delete(0);

        // A grant needs an idle cycle, a non-full FIFO and a request.
        if (!m_write && !fifo_full && (req0 || req1)) begin
            if (req0 && req1) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
                w = 1'b0;
`else
                w = !m_last;
`endif
            end else begin
                w = req1;
            end
            m_last  = w;
            m_gid   = w;
            m_data  = w ? data1 : data0;
            m_write = 1'b1;
        end else begin
            m_write = 1'b0;
        end

        #1;
        fifo_full = (fq.size() == DEPTH);
        rd        = 1'b0;
        if (ack0_s && q0.size() > 0) q0.delete(0);
        if (ack1_s && q1.size() > 0) q1.delete(0);
        present();
    endtask

    task automatic run_idle(input int max_cycles);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while ((q0.size() != 0 || q1.size() != 0 || m_write) && n < max_cycles);
        check("timeout", (q0.size() != 0 || q1.size() != 0 || m_write), 0);
    endtask

    initial begin
        int           st;
        int           r;
        logic [B-1:0] exp_data[4];
        logic         exp_gid[4];

        // ---- single request ----------------------------------------------
        do_reset();
        q0.push_back(8'hA5);
        present();
        st = cyc;
        run_idle(20);
        check("single_count", wlog.size(), 1);
        if (wlog.size() == 1) begin
            check("single_cyc", wlog[0].cyc, st + 1);
            check("single_data", wlog[0].data, 8'hA5);
            check("single_gid", wlog[0].gid, 0);
        end

        // ---- contention --------------------------------------------------
        do_reset();
        q0 = '{8'h11, 8'h11};
        q1 = '{8'h22, 8'h22};
        present();
        st = cyc;
        run_idle(40);
`ifdef FIFO_ARB_FIXED_PRIO_EN
        exp_data = '{8'h11, 8'h11, 8'h22, 8'h22};
        exp_gid  = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
        exp_data = '{8'h11, 8'h22, 8'h11, 8'h22};
        exp_gid  = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        check("cont_count", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            check("cont_cyc", wlog[i].cyc, st + 1 + 2 * i);
            check("cont_data", wlog[i].data, exp_data[i]);
            check("cont_gid", wlog[i].gid, exp_gid[i]);
        end

        // ---- full stall --------------------------------------------------
        do_reset();
        q0 = '{8'h01, 8'h02, 8'h03, 8'h04};
        present();
        run_idle(40);
        check("fill_count", wlog.size(), 4);
        check("fill_full", fifo_full, 1);
        q1.push_back(8'h55);
        present();
        repeat (6) cycle();
        check("stall_no_write", wlog.size(), 4);
        check("stall_pending", req1, 1);
        rd = 1'b1;
        r  = cyc;
        run_idle(20);
        check("stall_count", wlog.size(), 5);
        if (wlog.size() == 5) begin
            check("stall_cyc", wlog[4].cyc, r + 2);
            check("stall_data", wlog[4].data, 8'h55);
            check("stall_gid", wlog[4].gid, 1);
        end
        check("stall_full_again", fifo_full, 1);
        check("stall_fifo_size", fq.size(), 4);
        if (fq.size() == 4) begin
            check("stall_fifo_head", fq[0], 8'h02);
            check("stall_fifo_tail", fq[3], 8'h55);
        end

        // ---- last slot ---------------------------------------------------
        do_reset();
        fq = '{8'hE1, 8'hE2, 8'hE3};
        q0.push_back(8'hAA);
        q1.push_back(8'hBB);
        present();
        repeat (8) cycle();
        check("last_count", wlog.size(), 1);
        if (wlog.size() == 1) check("last_data", wlog[0].data, 8'hAA);
        check("last_full", fifo_full, 1);
        check("last_req1_pending", req1, 1);
        check("last_q1_left", q1.size(), 1);

        // ---- reset during WRITE ------------------------------------------
        do_reset();
        q0.push_back(8'h77);
        present();
        cycle();
        check("rw_in_write", fifo_wr, 1);
        reset = 1'b1;
        #1;
        check("rw_fifo_wr", fifo_wr, 0);
        check("rw_ack0", ack0, 0);
        check("rw_busy", busy, 0);
        do_reset();
        q0.push_back(8'h77);
        q1.push_back(8'h88);
        present();
        st = cyc;
        run_idle(20);
        check("rw_count", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("rw_first_gid", wlog[0].gid, 0);
            check("rw_first_data", wlog[0].data, 8'h77);
            check("rw_first_cyc", wlog[0].cyc, st + 1);
            check("rw_second_data", wlog[1].data, 8'h88);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Two-port write arbiter that shares a single B-bit FIFO write port between two independent producers. Each producer holds a level request with data until it receives a one-cycle acknowledge. The arbiter selects a winner (round-robin by default), drives the FIFO's `wr`/`w_data` inputs, and never issues a write while the FIFO reports full. It sits directly in front of the FIFO's write side; the FIFO's read side is untouched.

## Interface
Parameters:
- `B`, 8, data word width; must match the FIFO word width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`  in  1  requester 0 write request, level; held until `ack0`.
- `data0`  in  B  requester 0 word; stable while `req0` is high.
- `ack0`  out  1  one-cycle pulse; word from requester 0 is being written.
- `req1`  in  1  requester 1 write request, level; held until `ack1`.
- `data1`  in  B  requester 1 word; stable while `req1` is high.
- `ack1`  out  1  one-cycle pulse; word from requester 1 is being written.
- `fifo_full`  in  1  FIFO `full` output.
- `fifo_wr`  out  1  FIFO `wr` input.
- `fifo_w_data`  out  B  FIFO `w_data` input.
- `grant_id`  out  1  source of the current or most recent write (0/1).
- `busy`  out  1  high while in state WRITE.

## Operation
- FSM with two states, IDLE and WRITE. Reset state is IDLE.
- IDLE: if `fifo_full`=0 and any request is high, choose a winner, register `fifo_w_data` = winner data, set `grant_id` = winner, go to WRITE. Otherwise stay in IDLE with all strobes low.
- WRITE: lasts exactly one cycle. `fifo_wr`=1, `busy`=1, and the winner's `ack` is 1. Always return to IDLE.
- Round-robin: `last_grant` register, reset value 1. With one request, that requester wins. With both requests, the winner is `~last_grant`. `last_grant` updates on the IDLE->WRITE transition.
- All outputs are registered. Outputs never depend combinationally on inputs.
- `fifo_wr` and `ack*` are never high outside WRITE. `ack0` and `ack1` are never high together.
- A request that drops before it is granted is ignored, with no error.
- Requester contract: drop `req` (or present the next word) on the clock edge that samples `ack`.

## Timing
- Reset values: `fifo_wr`=0, `ack0`=0, `ack1`=0, `busy`=0, `grant_id`=0, `fifo_w_data`=0, `last_grant`=1.
- Latency: request seen in IDLE at cycle t gives `fifo_wr`/`ack` high during cycle t+1. The FIFO captures the word at the edge that ends t+1.
- Throughput: at most one write every 2 cycles. The IDLE cycle after WRITE sees `fifo_full` already updated by that write, so a FIFO with one free slot is never overwritten.
- Full: while `fifo_full`=1, the FSM holds in IDLE and the requests stay pending. The first IDLE cycle with `fifo_full`=0 grants.
- Simultaneous requests with `fifo_full`=0: grants alternate 0,1,0,1... starting with requester 0 after reset.
- Reset mid-WRITE: outputs clear immediately (asynchronously). The in-flight word may or may not reach the FIFO. Requesters that have not seen a sampled `ack` must re-request.

## Configuration
- `FIFO_ARB_FIXED_PRIO_EN` defined: fixed priority. Requester 0 always wins when both request; `last_grant` is not implemented.
- `FIFO_ARB_FIXED_PRIO_EN` undefined (default): round-robin as above.
- Ports and timing are identical in both builds.

## Test plan
- Single request: `req0`=1, `data0`=8'hA5, FIFO empty -> one cycle later `fifo_wr`=1, `fifo_w_data`=8'hA5, `ack0`=1, `grant_id`=0; then IDLE.
- Contention: `req0` and `req1` held continuously, data 8'h11/8'h22 -> writes alternate 11,22,11,22 at cycles 1,3,5,7 after start; never two acks at once.
- Full stall (W=2): fill 4 words, keep `req1` high -> no `fifo_wr` while `fifo_full`=1. One FIFO read -> write issued 2 cycles later, `fifo_full` back to 1, FIFO holds no overwritten data.
- Last slot: 3 words stored, both requests high -> exactly one write, the other requester stays pending with no ack.
- Reset during WRITE: assert `reset` mid-cycle -> `fifo_wr`, `ack*`, `busy` drop to 0 at once; after release, first tie grants requester 0.
- `FIFO_ARB_FIXED_PRIO_EN` build: both requests held -> requester 0 acked on every write while `req0` stays high; requester 1 is granted only when `req0`=0.
